md_unit: RTL and testbench



---
 rtl/md_unit_pkg.sv | 13 +
 rtl/md_calc.sv | 39 +++
 rtl/md_unit.sv | 58 +++++
 tb/tb_md_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: operation encodings and default latencies shared by md_unit, ctrl_E and the stall unit
package md_unit_pkg;
   localparam logic [2:0] MD_NOP   = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;
   localparam int DEF_WIDTH       = 32;
   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational next-{HI,LO} from the latched operation and operands
module md_calc
   import md_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0] div_b, mag_a, mag_b, q_u, r_u, q_m, r_m, q_s, r_s;
   logic b_zero;
   // Signed divide works on magnitudes; MIN/-1 falls out as MIN with remainder 0
   always_comb begin
      b_zero  = b == '0;
      div_b   = b_zero ? ONE : b;
      prod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      q_u     = a / div_b;
      r_u     = a % div_b;
      mag_a   = a[WIDTH-1] ? -a : a;
      mag_b   = b[WIDTH-1] ? -b : div_b;
      q_m     = mag_a / mag_b;
      r_m     = mag_a % mag_b;
      q_s     = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_m : q_m;
      r_s     = a[WIDTH-1] ? -r_m : r_m;
      {next_hi, next_lo} = op == MD_MULT  ? prod_s :
                           op == MD_MULTU ? prod_u :
                           b_zero         ? {hi, lo} :
                           op == MD_DIV   ? {r_s, q_s} :
                           op == MD_DIVU  ? {r_u, q_u} : {hi, lo};
   end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide sequencer with HI/LO registers
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       MDOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;
   logic [CW-1:0] cnt, lat;
   logic [2:0] op_q;
   logic [WIDTH-1:0] a_q, b_q, next_hi, next_lo;
   logic is_md;
   assign is_md = MDOp inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
   assign lat   = MDOp inside {MD_DIV, MD_DIVU} ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
   md_calc #(.WIDTH(WIDTH)) u_calc (
      .op(op_q), .a(a_q), .b(b_q), .hi(HI), .lo(LO),
      .next_hi(next_hi), .next_lo(next_lo)
   );
   // Start while Busy is dropped on purpose: the hazard unit never issues then
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Busy <= 1'b0;
         cnt  <= '0;
         op_q <= MD_NOP;
         a_q  <= '0;
         b_q  <= '0;
         HI   <= '0;
         LO   <= '0;
      end else if (Busy) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            Busy <= 1'b0;
            HI   <= next_hi;
            LO   <= next_lo;
         end
      end else if (Start) begin
         if (is_md) begin
            Busy <= 1'b1;
            cnt  <= lat;
            op_q <= MDOp;
            a_q  <= A;
            b_q  <= B;
         end else if (MDOp == MD_MTHI) HI <= A;
         else if (MDOp == MD_MTLO) LO <= A;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit at default and minimal-latency 16-bit configurations
module tb_md_unit;
   import md_unit_pkg::*;
   logic Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
   logic [2:0] MDOp = MD_NOP;
   logic [31:0] A = '0, B = '0;
   logic Busy;
   logic [31:0] HI, LO;
   logic s2 = 1'b0;
   logic [2:0] op2 = MD_NOP;
   logic [15:0] a2 = '0, b2 = '0;
   logic busy2;
   logic [15:0] hi2, lo2;
   int compared = 0, mismatched = 0;
   always #5 Clk = ~Clk;
   md_unit dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
      .Busy(Busy), .HI(HI), .LO(LO)
   );
   md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_small (
      .Clk(Clk), .Reset(Reset), .Start(s2), .MDOp(op2), .A(a2), .B(b2),
      .Busy(busy2), .HI(hi2), .LO(lo2)
   );
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1; MDOp = op; A = a; B = b;
      tick();
      Start = 1'b0; MDOp = MD_NOP;
   endtask
   task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      s2 = 1'b1; op2 = op; a2 = a; b2 = b;
      tick();
      s2 = 1'b0; op2 = MD_NOP;
   endtask
   task automatic wait_idle(output int n);
      n = 0;
      while (Busy && n < 100) begin
         n++;
         tick();
      end
   endtask
   task automatic test_reset();
      #1 Reset = 1'b1;
      #2;
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", Busy); end
      compared++; if (HI !== 32'h0) begin mismatched++; $display("FAIL reset_hi: got %h want 00000000", HI); end
      compared++; if (LO !== 32'h0) begin mismatched++; $display("FAIL reset_lo: got %h want 00000000", LO); end
      compared++; if (busy2 !== 1'b0 || hi2 !== 16'h0 || lo2 !== 16'h0) begin mismatched++; $display("FAIL reset_small: got %b %h %h want 0 0000 0000", busy2, hi2, lo2); end
      Reset = 1'b0;
      tick();
   endtask
   task automatic test_mult();
      int n;
      issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
      wait_idle(n);
      compared++; if (n != 5) begin mismatched++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
      compared++; if (HI !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      compared++; if (LO !== 32'hFFFFFFFA) begin mismatched++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
   endtask
   task automatic test_multu();
      int n;
      issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(n);
      compared++; if (n != 5) begin mismatched++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
      compared++; if (HI !== 32'hFFFFFFFE) begin mismatched++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
      compared++; if (LO !== 32'h00000001) begin mismatched++; $display("FAIL multu_lo: got %h want 00000001", LO); end
   endtask
   task automatic test_div();
      int n;
      issue(MD_DIV, -32'sd7, 32'd2);
      wait_idle(n);
      compared++; if (n != 10) begin mismatched++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
      compared++; if (LO !== 32'hFFFFFFFD) begin mismatched++; $display("FAIL div_lo: got %h want fffffffd", LO); end
      compared++; if (HI !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL div_hi: got %h want ffffffff", HI); end
      issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
      wait_idle(n);
      compared++; if ({HI, LO} !== {32'h00000001, 32'hFFFFFFFD}) begin mismatched++; $display("FAIL div_neg_divisor: got %h_%h want 00000001_fffffffd", HI, LO); end
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      compared++; if ({HI, LO} !== {32'h00000000, 32'h80000000}) begin mismatched++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", HI, LO); end
   endtask
   task automatic test_divu();
      int n;
      issue(MD_DIVU, 32'hFFFFFFF9, 32'd16);
      wait_idle(n);
      compared++; if (n != 10) begin mismatched++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
      compared++; if ({HI, LO} !== {32'h00000009, 32'h0FFFFFFF}) begin mismatched++; $display("FAIL divu_result: got %h_%h want 00000009_0fffffff", HI, LO); end
   endtask
   task automatic test_div_zero();
      int n;
      Start = 1'b1; MDOp = MD_MTHI; A = 32'h11;
      tick();
      Start = 1'b0;
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL mthi_busy: got %b want 0", Busy); end
      compared++; if ({HI, LO} !== {32'h00000011, 32'h0FFFFFFF}) begin mismatched++; $display("FAIL mthi_regs: got %h_%h want 00000011_0fffffff", HI, LO); end
      Start = 1'b1; MDOp = MD_MTLO; A = 32'h22;
      tick();
      Start = 1'b0;
      compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL mtlo_busy: got %b want 0", Busy); end
      compared++; if ({HI, LO} !== {32'h00000011, 32'h00000022}) begin mismatched++; $display("FAIL mtlo_regs: got %h_%h want 00000011_00000022", HI, LO); end
      Start = 1'b1; MDOp = 3'd7; A = 32'h99;
      tick();
      Start = 1'b0; MDOp = MD_NOP;
      compared++; if ({Busy, HI, LO} !== {1'b0, 32'h00000011, 32'h00000022}) begin mismatched++; $display("FAIL reserved_op: got %b %h_%h want 0 00000011_00000022", Busy, HI, LO); end
      issue(MD_DIVU, 32'd7, 32'd0);
      wait_idle(n);
      compared++; if (n != 10) begin mismatched++; $display("FAIL divzero_busy_cycles: got %0d want 10", n); end
      compared++; if ({HI, LO} !== {32'h00000011, 32'h00000022}) begin mismatched++; $display("FAIL divzero_regs: got %h_%h want 00000011_00000022", HI, LO); end
   endtask
   task automatic test_ignore_while_busy();
      int n;
      issue(MD_MULT, 32'd6, 32'd7);
      Start = 1'b1; MDOp = MD_MTLO; A = 32'd5; B = 32'd9;
      tick();
      MDOp = MD_MULT; A = 32'd100; B = 32'd100;
      tick();
      Start = 1'b0; MDOp = MD_NOP; A = 32'hDEAD; B = 32'd1;
      compared++; if ({Busy, HI, LO} !== {1'b1, 32'h00000011, 32'h00000022}) begin mismatched++; $display("FAIL busy_start_ignored: got %b %h_%h want 1 00000011_00000022", Busy, HI, LO); end
      wait_idle(n);
      compared++; if (n != 3) begin mismatched++; $display("FAIL busy_remaining_cycles: got %0d want 3", n); end
      compared++; if ({HI, LO} !== {32'h00000000, 32'h0000002A}) begin mismatched++; $display("FAIL latched_operands: got %h_%h want 00000000_0000002a", HI, LO); end
   endtask
   task automatic test_reset_mid_op();
      Start = 1'b1; MDOp = MD_MTHI; A = 32'h33;
      tick();
      Start = 1'b0;
      issue(MD_DIV, 32'd100, 32'd3);
      repeat (3) tick();
      #2 Reset = 1'b1;
      #1;
      compared++; if ({Busy, HI, LO} !== {1'b0, 32'h0, 32'h0}) begin mismatched++; $display("FAIL async_reset_mid: got %b %h_%h want 0 00000000_00000000", Busy, HI, LO); end
      #1 Reset = 1'b0;
      repeat (12) tick();
      compared++; if ({Busy, HI, LO} !== {1'b0, 32'h0, 32'h0}) begin mismatched++; $display("FAIL reset_no_late_write: got %b %h_%h want 0 00000000_00000000", Busy, HI, LO); end
   endtask
   task automatic test_small();
      issue16(MD_MULT, 16'hFFFE, 16'd3);
      compared++; if (busy2 !== 1'b1) begin mismatched++; $display("FAIL small_busy_set: got %b want 1", busy2); end
      tick();
      compared++; if (busy2 !== 1'b0) begin mismatched++; $display("FAIL small_busy_clear: got %b want 0", busy2); end
      compared++; if ({hi2, lo2} !== {16'hFFFF, 16'hFFFA}) begin mismatched++; $display("FAIL small_mult: got %h_%h want ffff_fffa", hi2, lo2); end
      issue16(MD_MULTU, 16'hFFFF, 16'hFFFF);
      tick();
      compared++; if ({busy2, hi2, lo2} !== {1'b0, 16'hFFFE, 16'h0001}) begin mismatched++; $display("FAIL small_multu: got %b %h_%h want 0 fffe_0001", busy2, hi2, lo2); end
      issue16(MD_DIV, 16'hFFF9, 16'd2);
      tick();
      compared++; if ({busy2, hi2, lo2} !== {1'b0, 16'hFFFF, 16'hFFFD}) begin mismatched++; $display("FAIL small_div: got %b %h_%h want 0 ffff_fffd", busy2, hi2, lo2); end
   endtask
   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_divu();
      test_div_zero();
      test_ignore_while_busy();
      test_reset_mid_op();
      test_small();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
